// File: rtl/csdf_tag_split.sv
// csdf_tag_split: pops one {tag,payload} token and emits it as 4 parts (q,q,q,q+r) on the flow selected by tag.
// Optional per-tag pop counters tok0_cnt/tok1_cnt are enabled by CSDF_SPLIT_STATS_EN.
module csdf_tag_split #(
  parameter int   WIDTH  = 33,
  parameter logic ATTESA = 1'b0,
  parameter logic AZIONE = 1'b1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_empty,
  output logic             in0_read,
  input  logic             out0_full,
  output logic             out0_wr,
  output logic [WIDTH-2:0] out0_data,
  input  logic             out1_full,
  output logic             out1_wr,
  output logic [WIDTH-2:0] out1_data
`ifdef CSDF_SPLIT_STATS_EN
  ,
  output logic [15:0]      tok0_cnt,
  output logic [15:0]      tok1_cnt
`endif
);
  localparam int PW = WIDTH - 1;
  typedef enum logic {S_ATTESA = ATTESA, S_AZIONE = AZIONE} state_t;
  state_t          state, state_n;
  logic [1:0]      cnt, cnt_n, r_r, r_n;
  logic            tag_r, tag_n, emit, sel_full, wr, last;
  logic [PW-1:0]   q_r, q_n, part;
  // rst gates the handshakes so a FIFO pop or push can never slip through during reset
  always_comb begin
    emit      = state == S_AZIONE;
    sel_full  = tag_r ? out1_full : out0_full;
    wr        = !rst && emit && !sel_full;
    last      = wr && cnt == 2'd3;
    in0_read  = !rst && !in0_empty && (!emit || last);
    part      = (cnt == 2'd3) ? q_r + PW'(r_r) : q_r;
    out0_wr   = wr && !tag_r;
    out1_wr   = wr && tag_r;
    out0_data = (emit && !tag_r) ? part : '0;
    out1_data = (emit && tag_r) ? part : '0;
    state_n   = in0_read ? S_AZIONE : (last ? S_ATTESA : state);
    cnt_n     = (in0_read || last) ? 2'd0 : (wr ? cnt + 2'd1 : cnt);
    tag_n     = in0_read ? in0_data[WIDTH-1] : tag_r;
    q_n       = in0_read ? {2'b00, in0_data[WIDTH-2:2]} : q_r;
    r_n       = in0_read ? in0_data[1:0] : r_r;
  end
  always_ff @(posedge ck) begin
    if (rst) begin
      state <= S_ATTESA;
      cnt   <= '0;
      tag_r <= 1'b0;
      q_r   <= '0;
      r_r   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      tag_r <= tag_n;
      q_r   <= q_n;
      r_r   <= r_n;
    end
  end
`ifdef CSDF_SPLIT_STATS_EN
  always_ff @(posedge ck) begin
    if (rst) begin
      tok0_cnt <= '0;
      tok1_cnt <= '0;
    end else if (in0_read) begin
      tok0_cnt <= tok0_cnt + {15'd0, !in0_data[WIDTH-1]};
      tok1_cnt <= tok1_cnt + {15'd0, in0_data[WIDTH-1]};
    end
  end
`endif
endmodule

// File: tb/tb_csdf_tag_split.sv
// tb_csdf_tag_split: directed steps against a FIFO model and per-flow scoreboards for csdf_tag_split.
module tb_csdf_tag_split;
  logic        ck = 1'b0;
  logic        rst, in0_empty, in0_read, out0_full, out0_wr, out1_full, out1_wr;
  logic [32:0] in0_data;
  logic [31:0] out0_data, out1_data;
`ifdef CSDF_SPLIT_STATS_EN
  logic [15:0] tok0_cnt, tok1_cnt;
`endif
  logic [32:0] fifo[$];
  logic [31:0] exp0[$], exp1[$];
  int          total = 0, bad = 0, n0 = 0, n1 = 0;
  logic [31:0] sum0 = 0;

  always #5 ck = ~ck;

  csdf_tag_split dut (
    .ck(ck), .rst(rst),
    .in0_data(in0_data), .in0_empty(in0_empty), .in0_read(in0_read),
    .out0_full(out0_full), .out0_wr(out0_wr), .out0_data(out0_data),
    .out1_full(out1_full), .out1_wr(out1_wr), .out1_data(out1_data)
`ifdef CSDF_SPLIT_STATS_EN
    , .tok0_cnt(tok0_cnt), .tok1_cnt(tok1_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    in0_empty = (fifo.size() == 0);
    in0_data  = in0_empty ? 33'd0 : fifo[0];
  endtask

  task automatic push_tok(input logic t, input logic [31:0] p);
    fifo.push_back({t, p});
    apply();
    #1;
  endtask

  task automatic expect_parts(input logic [32:0] t);
    logic [31:0] q;
    q = {2'b00, t[31:2]};
    for (int i = 0; i < 4; i++) begin
      if (t[32]) exp1.push_back(i == 3 ? q + 32'(t[1:0]) : q);
      else exp0.push_back(i == 3 ? q + 32'(t[1:0]) : q);
    end
  endtask

  // sample at the current (mid-low) time, then advance one clock
  task automatic cyc();
    if (in0_read === 1'b1) begin
      if (fifo.size() == 0) check("read_on_empty", 32'd1, 32'd0);
      else expect_parts(fifo.pop_front());
    end
    if (out0_wr === 1'b1) begin
      n0++;
      if (exp0.size() == 0) check("out0_unexpected_wr", 32'd1, 32'd0);
      else begin
        check("out0_data", out0_data, exp0.pop_front());
        sum0 += out0_data;
      end
    end
    if (out1_wr === 1'b1) begin
      n1++;
      if (exp1.size() == 0) check("out1_unexpected_wr", 32'd1, 32'd0);
      else check("out1_data", out1_data, exp1.pop_front());
    end
    @(posedge ck);
    #1 apply();
    @(negedge ck);
    #1;
  endtask

  task automatic drain(input int max);
    int k = 0;
    while ((fifo.size() != 0 || exp0.size() != 0 || exp1.size() != 0) && k < max) begin
      cyc();
      k++;
    end
    check("drain_timeout", 32'(k < max), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    out0_full = 1'b0;
    out1_full = 1'b0;
    fifo.push_back({1'b1, 32'd10});
    apply();
    @(negedge ck);
    #1;
    repeat (2) begin
      check("rst_read", 32'(in0_read), 32'd0);
      check("rst_wr", 32'({out0_wr, out1_wr}), 32'd0);
      cyc();
    end
    rst = 1'b0;
    #1;
    check("read_after_rst", 32'(in0_read), 32'd1);
    check("no_wr_on_pop", 32'({out0_wr, out1_wr}), 32'd0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      check("t10_out1_wr", 32'(out1_wr), 32'd1);
      check("t10_out0_wr", 32'(out0_wr), 32'd0);
      cyc();
    end
    check("t10_idle_wr", 32'({out0_wr, out1_wr}), 32'd0);
    check("t10_done", 32'(exp1.size()), 32'd0);
`ifdef CSDF_SPLIT_STATS_EN
    check("tok1_cnt_one", 32'(tok1_cnt), 32'd1);
`endif

    out1_full = 1'b1;
    n0 = 0;
    sum0 = 0;
    push_tok(1'b0, 32'hFFFF_FFFF);
    drain(20);
    check("max_writes", 32'(n0), 32'd4);
    check("max_sum", sum0, 32'hFFFF_FFFF);
    out1_full = 1'b0;

    n0 = 0;
    push_tok(1'b0, 32'd8);
    check("stall_pop", 32'(in0_read), 32'd1);
    cyc();
    repeat (2) begin
      check("stall_pre_wr", 32'(out0_wr), 32'd1);
      cyc();
    end
    out0_full = 1'b1;
    #1;
    repeat (3) begin
      check("stall_wr", 32'(out0_wr), 32'd0);
      check("stall_hold", out0_data, 32'd2);
      check("stall_no_read", 32'(in0_read), 32'd0);
      cyc();
    end
    out0_full = 1'b0;
    #1;
    drain(20);
    check("stall_writes", 32'(n0), 32'd4);

    fifo.push_back({1'b0, 32'd4});
    push_tok(1'b1, 32'd7);
    check("b2b_pop", 32'(in0_read), 32'd1);
    cyc();
    for (int i = 0; i < 8; i++) begin
      check("b2b_wr0", 32'(out0_wr), 32'(i < 4));
      check("b2b_wr1", 32'(out1_wr), 32'(i >= 4));
      check("b2b_read", 32'(in0_read), 32'(i == 3));
      cyc();
    end
    check("b2b_idle", 32'({out0_wr, out1_wr}), 32'd0);

    fifo.push_back({1'b1, 32'd20});
    push_tok(1'b0, 32'd12);
    check("mid_pop", 32'(in0_read), 32'd1);
    cyc();
    repeat (2) begin
      check("mid_wr1", 32'(out1_wr), 32'd1);
      cyc();
    end
    rst = 1'b1;
    #1;
    check("mid_rst_wr", 32'({out0_wr, out1_wr}), 32'd0);
    check("mid_rst_read", 32'(in0_read), 32'd0);
    exp1.delete();
    cyc();
    rst = 1'b0;
    #1;
`ifdef CSDF_SPLIT_STATS_EN
    check("tok1_cnt_cleared", 32'(tok1_cnt), 32'd0);
`endif
    check("post_rst_wr1", 32'(out1_wr), 32'd0);
    check("post_rst_read", 32'(in0_read), 32'd1);
    n1 = 0;
    drain(20);
    check("post_rst_out1_writes", 32'(n1), 32'd0);
`ifdef CSDF_SPLIT_STATS_EN
    check("tok0_cnt_after", 32'(tok0_cnt), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
